// File: rtl/run_monitor.sv
// Run control for multi-core harnesses: counts RUN cycles, tracks halts,
// ends on all-halted or timeout, then streams every core's registers out.
module run_monitor #(
    parameter int NUM_CPUS = 2,
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32,
    localparam int CPU_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    timeout_cycles,
    input  logic [NUM_CPUS-1:0] halted,
    output logic                reg_rd_en,
    output logic [CPU_W-1:0]    reg_rd_cpu,
    output logic [IDX_W-1:0]    reg_rd_idx,
    input  logic [XLEN-1:0]     reg_rd_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [CPU_W-1:0]    dump_cpu,
    output logic [IDX_W-1:0]    dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic [NUM_CPUS-1:0] halted_mask,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                running,
    output logic                done,
    output logic                timed_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] RD_REQ = 3'd2;
    localparam logic [2:0] RD_CAP = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [CPU_W-1:0] LAST_CPU = CPU_W'(NUM_CPUS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [2:0]          state;
    logic [CNT_W-1:0]    timeout_q;
    logic [CPU_W-1:0]    cur_cpu;
    logic [IDX_W-1:0]    cur_idx;
    logic [NUM_CPUS-1:0] mask_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_beat;

    assign mask_nxt  = halted_mask | halted;
    assign cnt_inc   = cycle_count + CNT_W'(1);
    assign last_beat = (cur_cpu == LAST_CPU) && (cur_idx == LAST_IDX);

    assign running    = (state == RUN);
    assign done       = (state == DONE);
    assign dump_valid = (state == OUT);
    assign reg_rd_en  = (state == RD_REQ);
    assign reg_rd_cpu = cur_cpu;
    assign reg_rd_idx = cur_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timeout_q   <= '0;
            cur_cpu     <= '0;
            cur_idx     <= '0;
            dump_cpu    <= '0;
            dump_idx    <= '0;
            dump_data   <= '0;
            halted_mask <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        halted_mask <= '0;
                        timed_out   <= 1'b0;
                        timeout_q   <= timeout_cycles;
                        cur_cpu     <= '0;
                        cur_idx     <= '0;
                        dump_cpu    <= '0;
                        dump_idx    <= '0;
                        dump_data   <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cnt_inc;
                    halted_mask <= mask_nxt;
                    // all-halted is tested first so it wins a same-cycle timeout
                    if (&mask_nxt) begin
                        timed_out <= 1'b0;
                        state     <= RD_REQ;
                    end else if (timeout_q != '0 && cnt_inc == timeout_q) begin
                        timed_out <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    dump_data <= reg_rd_data;
                    dump_cpu  <= cur_cpu;
                    dump_idx  <= cur_idx;
                    state     <= OUT;
                end
                OUT: begin
                    if (dump_ready) begin
                        if (last_beat) begin
                            state <= DONE;
                        end else begin
                            if (cur_idx == LAST_IDX) begin
                                cur_idx <= '0;
                                cur_cpu <= cur_cpu + CPU_W'(1);
                            end else begin
                                cur_idx <= cur_idx + IDX_W'(1);
                            end
                            state <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
